// File: rtl/usb_tx_sequencer.sv
// rtl/usb_tx_sequencer.sv - USB 1.0 TX packet sequencer (SYNC, PID, DATA, CRC16, EOP)
// Optional macro USB_TX_UNDERRUN_EN: FIFO underrun in DATA truncates the packet and pulses tx_err.
module usb_tx_sequencer #(
  parameter int         MAX_LEN   = 64,
  parameter logic [7:0] SYNC_BYTE = 8'h80
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic [3:0] pid,
  input  logic [6:0] data_len,
  input  logic [7:0] fifo_rdata,
  input  logic       fifo_empty,
  output logic       fifo_rd,
  input  logic       byte_req,
  output logic       byte_load,
  output logic [7:0] byte_out,
  output logic       send_eop,
  input  logic       eop_done,
  output logic       busy,
`ifdef USB_TX_UNDERRUN_EN
  output logic       tx_err,
`endif
  output logic       tx_done
);

  typedef enum logic [2:0] {
    S_IDLE, S_SYNC, S_PID, S_DATA, S_CRC_LO, S_CRC_HI, S_WAIT_LAST, S_EOP
  } state_t;

  localparam logic [6:0] MAX_LEN7 = 7'(MAX_LEN);

  state_t      state_q, state_d;
  logic [3:0]  pid_q, pid_d;
  logic [6:0]  cnt_q, cnt_d;
  logic [15:0] crc_q, crc_d;
  logic        byte_load_q, byte_load_d;
  logic [7:0]  byte_out_q, byte_out_d;
  logic        fifo_rd_q, fifo_rd_d;
  logic        send_eop_q, send_eop_d;
  logic        busy_q, busy_d;
  logic        tx_done_q, tx_done_d;
`ifdef USB_TX_UNDERRUN_EN
  logic        tx_err_q, tx_err_d;
`endif

  logic       can_load;
  logic       is_data;
  logic [6:0] len_clamped;

  // Reflected CRC16 (poly 0x8005), payload bits consumed LSB-first.
  function automatic logic [15:0] crc16_byte(input logic [15:0] c, input logic [7:0] b);
    logic [15:0] r;
    r = c;
    for (int i = 0; i < 8; i++) begin
      if (r[0] ^ b[i]) r = (r >> 1) ^ 16'hA001;
      else             r = r >> 1;
    end
    return r;
  endfunction

  // The cycle right after a load is blind to byte_req to absorb the consumer's deassert latency.
  assign can_load    = byte_req && !byte_load_q;
  assign is_data     = (pid_q[1:0] == 2'b11);
  assign len_clamped = (data_len > MAX_LEN7) ? MAX_LEN7 : data_len;

  always_comb begin
    state_d     = state_q;
    pid_d       = pid_q;
    cnt_d       = cnt_q;
    crc_d       = crc_q;
    byte_load_d = 1'b0;
    byte_out_d  = byte_out_q;
    fifo_rd_d   = 1'b0;
    send_eop_d  = 1'b0;
    busy_d      = busy_q;
    tx_done_d   = 1'b0;
`ifdef USB_TX_UNDERRUN_EN
    tx_err_d    = 1'b0;
`endif
    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d = S_SYNC;
          busy_d  = 1'b1;
          pid_d   = pid;
          cnt_d   = len_clamped;
          crc_d   = 16'hFFFF;
        end
      end
      S_SYNC: begin
        if (can_load) begin
          byte_load_d = 1'b1;
          byte_out_d  = SYNC_BYTE;
          state_d     = S_PID;
        end
      end
      S_PID: begin
        if (can_load) begin
          byte_load_d = 1'b1;
          byte_out_d  = {~pid_q, pid_q};
          if (!is_data)           state_d = S_WAIT_LAST;
          else if (cnt_q == 7'd0) state_d = S_CRC_LO;
          else                    state_d = S_DATA;
        end
      end
      S_DATA: begin
        if (can_load) begin
          if (!fifo_empty) begin
            byte_load_d = 1'b1;
            byte_out_d  = fifo_rdata;
            fifo_rd_d   = 1'b1;
            crc_d       = crc16_byte(crc_q, fifo_rdata);
            cnt_d       = cnt_q - 7'd1;
            if (cnt_q == 7'd1) state_d = S_CRC_LO;
          end
`ifdef USB_TX_UNDERRUN_EN
          else begin
            tx_err_d = 1'b1;
            state_d  = S_WAIT_LAST;
          end
`endif
        end
      end
      S_CRC_LO: begin
        if (can_load) begin
          byte_load_d = 1'b1;
          byte_out_d  = ~crc_q[7:0];
          state_d     = S_CRC_HI;
        end
      end
      S_CRC_HI: begin
        if (can_load) begin
          byte_load_d = 1'b1;
          byte_out_d  = ~crc_q[15:8];
          state_d     = S_WAIT_LAST;
        end
      end
      S_WAIT_LAST: begin
        if (can_load) begin
          send_eop_d = 1'b1;
          state_d    = S_EOP;
        end
      end
      S_EOP: begin
        if (eop_done) begin
          state_d   = S_IDLE;
          tx_done_d = 1'b1;
          busy_d    = 1'b0;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_IDLE;
      pid_q       <= 4'd0;
      cnt_q       <= 7'd0;
      crc_q       <= 16'd0;
      byte_load_q <= 1'b0;
      byte_out_q  <= 8'd0;
      fifo_rd_q   <= 1'b0;
      send_eop_q  <= 1'b0;
      busy_q      <= 1'b0;
      tx_done_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      pid_q       <= pid_d;
      cnt_q       <= cnt_d;
      crc_q       <= crc_d;
      byte_load_q <= byte_load_d;
      byte_out_q  <= byte_out_d;
      fifo_rd_q   <= fifo_rd_d;
      send_eop_q  <= send_eop_d;
      busy_q      <= busy_d;
      tx_done_q   <= tx_done_d;
    end
  end

`ifdef USB_TX_UNDERRUN_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) tx_err_q <= 1'b0;
    else     tx_err_q <= tx_err_d;
  end
  assign tx_err = tx_err_q;
`endif

  assign fifo_rd   = fifo_rd_q;
  assign byte_load = byte_load_q;
  assign byte_out  = byte_out_q;
  assign send_eop  = send_eop_q;
  assign busy      = busy_q;
  assign tx_done   = tx_done_q;

endmodule

// File: tb/tb_usb_tx_sequencer.sv
// tb/tb_usb_tx_sequencer.sv - directed, table-driven bench for usb_tx_sequencer
module tb_usb_tx_sequencer;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start = 1'b0;
  logic [3:0] pid = 4'd0;
  logic [6:0] data_len = 7'd0;
  logic [7:0] fifo_rdata;
  logic       fifo_empty;
  logic       fifo_rd;
  logic       byte_req = 1'b0;
  logic       byte_load;
  logic [7:0] byte_out;
  logic       send_eop;
  logic       eop_done = 1'b0;
  logic       busy;
  logic       tx_done;
`ifdef USB_TX_UNDERRUN_EN
  logic       tx_err;
`endif

  usb_tx_sequencer dut (
    .clk(clk), .rst(rst), .start(start), .pid(pid), .data_len(data_len),
    .fifo_rdata(fifo_rdata), .fifo_empty(fifo_empty), .fifo_rd(fifo_rd),
    .byte_req(byte_req), .byte_load(byte_load), .byte_out(byte_out),
    .send_eop(send_eop), .eop_done(eop_done), .busy(busy),
`ifdef USB_TX_UNDERRUN_EN
    .tx_err(tx_err),
`endif
    .tx_done(tx_done)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  // Bench FIFO: write side owned by the stimulus, read side by the pop process.
  logic [7:0] fifo_mem [0:255];
  int wr_ptr = 0;
  int rd_ptr = 0;
  logic [7:0] pay[$];
  logic [7:0] exp_q[$];

  always @(posedge clk) if (fifo_rd && rd_ptr != wr_ptr) rd_ptr <= rd_ptr + 1;

  always @(negedge clk) begin
    #1;
    fifo_empty = (rd_ptr == wr_ptr);
    fifo_rdata = fifo_mem[rd_ptr % 256];
  end

  // Observation of DUT outputs on the falling edge.
  logic [7:0] got[$];
  int rd_cnt = 0, eop_cnt = 0, done_cnt = 0, err_cnt = 0;
  int b2b_cnt = 0, rd_noload_cnt = 0, overlap_cnt = 0;
  bit prev_load = 1'b0;

  always @(negedge clk) begin
    if (!rst) begin
      if (byte_load) got.push_back(byte_out);
      if (byte_load && prev_load) b2b_cnt++;
      prev_load = byte_load;
      if (fifo_rd) rd_cnt++;
      if (fifo_rd && !byte_load) rd_noload_cnt++;
      if (send_eop) eop_cnt++;
      if (tx_done) done_cnt++;
      if (tx_done && busy) overlap_cnt++;
`ifdef USB_TX_UNDERRUN_EN
      if (tx_err) err_cnt++;
`endif
    end
  end

  // Line driver stand-in: answers send_eop after a few cycles, or emits a stray eop_done on request.
  int stray_req = 0, stray_ack = 0;
  always @(negedge clk) begin
    if (send_eop) begin
      repeat (3) @(negedge clk);
      eop_done = 1'b1;
      @(negedge clk);
      eop_done = 1'b0;
    end else if (stray_req != stray_ack) begin
      stray_ack = stray_req;
      eop_done = 1'b1;
      @(negedge clk);
      eop_done = 1'b0;
    end
  end

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0d (0x%0h) expected=%0d (0x%0h)", name, act, act, exp, exp);
    end
  endtask

  task automatic fill(input int n, input int base);
    for (int i = 0; i < n; i++) begin
      fifo_mem[wr_ptr % 256] = 8'(base + i);
      pay.push_back(8'(base + i));
      wr_ptr = wr_ptr + 1;
    end
  endtask

  // Independent reference: MSB-first CRC over bit-reversed input, result bit-reversed.
  function automatic logic [15:0] crc_ref(input int n);
    logic [15:0] c, r;
    logic [7:0]  b;
    logic        fb;
    c = 16'hFFFF;
    for (int i = 0; i < n; i++) begin
      b = pay[i];
      for (int j = 0; j < 8; j++) begin
        fb = c[15] ^ b[j];
        c  = {c[14:0], 1'b0};
        if (fb) c = c ^ 16'h8005;
      end
    end
    for (int k = 0; k < 16; k++) r[k] = c[15-k];
    return r;
  endfunction

  task automatic build_exp(input logic [3:0] p, input int len);
    int eff;
    logic [15:0] c;
    exp_q.delete();
    exp_q.push_back(8'h80);
    exp_q.push_back({~p, p});
    if (p[1:0] == 2'b11) begin
      eff = (len > 64) ? 64 : len;
      for (int i = 0; i < eff; i++) exp_q.push_back(pay[i]);
      c = crc_ref(eff);
      exp_q.push_back(~c[7:0]);
      exp_q.push_back(~c[15:8]);
    end
  endtask

  int base_got, base_rd, base_eop, base_done, base_err;

  task automatic send(input logic [3:0] p, input int len);
    @(negedge clk); #2;
    base_got = got.size(); base_rd = rd_cnt; base_eop = eop_cnt;
    base_done = done_cnt; base_err = err_cnt;
    pid = p; data_len = 7'(len); start = 1'b1;
    @(negedge clk); #2;
    start = 1'b0;
  endtask

  task automatic wait_got(input int n, input int budget, input string name);
    for (int i = 0; i < budget; i++) begin
      if (got.size() - base_got >= n) break;
      @(negedge clk); #2;
    end
    chk({name, " reached load count"}, int'(got.size() - base_got >= n), 1);
  endtask

  task automatic wait_done(input int budget, input string name);
    for (int i = 0; i < budget; i++) begin
      @(negedge clk); #2;
      if (done_cnt != base_done) break;
    end
    chk({name, " tx_done pulses"}, done_cnt - base_done, 1);
    chk({name, " busy low at done"}, int'(busy), 0);
  endtask

  task automatic check_pkt(input string name, input int exp_rd);
    int n;
    n = got.size() - base_got;
    chk({name, " load count"}, n, exp_q.size());
    for (int i = 0; i < n && i < exp_q.size(); i++)
      chk($sformatf("%s byte%0d", name, i), int'(got[base_got + i]), int'(exp_q[i]));
    chk({name, " fifo_rd count"}, rd_cnt - base_rd, exp_rd);
    chk({name, " send_eop count"}, eop_cnt - base_eop, 1);
  endtask

  typedef struct {
    string      name;
    logic [3:0] pid;
    int         len;
    int         nfill;
    int         base;
    int         exp_pid_byte;
    int         exp_loads;
    int         exp_rd;
  } vec_t;

  vec_t vecs[6];

  initial begin
    vecs[0] = '{"ack",   4'b0010, 3, 0, 8'h00, 8'hD2, 2, 0};
    vecs[1] = '{"nak",   4'b1010, 0, 0, 8'h00, 8'h5A, 2, 0};
    vecs[2] = '{"data0z",4'b0011, 0, 0, 8'h00, 8'hC3, 4, 0};
    vecs[3] = '{"data1", 4'b1011, 4, 4, 8'h00, 8'h4B, 8, 4};
    vecs[4] = '{"data0", 4'b0011, 3, 3, 8'hA5, 8'hC3, 7, 3};
    vecs[5] = '{"stall", 4'b1110, 0, 0, 8'h00, 8'h1E, 2, 0};

    // Reset and idle
    repeat (3) @(negedge clk);
    chk("reset busy", int'(busy), 0);
    chk("reset byte_load", int'(byte_load), 0);
    #2 rst = 1'b0;
    byte_req = 1'b1;
    repeat (10) @(negedge clk);
    #2;
    chk("idle no loads", got.size(), 0);
    chk("idle busy", int'(busy), 0);
    chk("idle tx_done", done_cnt, 0);
    stray_req++;
    repeat (5) @(negedge clk);
    #2;
    chk("stray eop_done in idle", done_cnt, 0);

    // Table-driven packets
    for (int v = 0; v < 6; v++) begin
      pay.delete();
      fill(vecs[v].nfill, vecs[v].base);
      send(vecs[v].pid, vecs[v].len);
      wait_done(200, vecs[v].name);
      build_exp(vecs[v].pid, vecs[v].len);
      chk({vecs[v].name, " pid byte"}, int'(got[base_got + 1]), vecs[v].exp_pid_byte);
      chk({vecs[v].name, " hand load count"}, got.size() - base_got, vecs[v].exp_loads);
      check_pkt(vecs[v].name, vecs[v].exp_rd);
      if (vecs[v].name == "data0z")
        chk("data0z crc bytes zero", int'({got[base_got + 2], got[base_got + 3]}), 0);
    end

    // byte_req held low mid-payload, stray eop_done while stalled
    pay.delete();
    fill(4, 8'h00);
    send(4'b1011, 4);
    wait_got(4, 50, "breq");
    byte_req = 1'b0;
    begin
      int n0;
      n0 = got.size();
      stray_req++;
      repeat (20) @(negedge clk);
      #2;
      chk("breq low no loads", got.size() - n0, 0);
      chk("breq low busy", int'(busy), 1);
    end
    byte_req = 1'b1;
    wait_done(200, "breq");
    build_exp(4'b1011, 4);
    check_pkt("breq", 4);

    // Length clamp with an ignored start mid-packet
    pay.delete();
    fill(64, 8'h40);
    send(4'b0011, 100);
    wait_got(12, 100, "clamp");
    pid = 4'b0010; data_len = 7'd0; start = 1'b1;
    @(negedge clk); #2;
    start = 1'b0;
    wait_done(600, "clamp");
    build_exp(4'b0011, 100);
    check_pkt("clamp", 64);
    begin
      int n0;
      n0 = got.size();
      repeat (10) @(negedge clk);
      #2;
      chk("clamp no queued start loads", got.size() - n0, 0);
      chk("clamp no queued start busy", int'(busy), 0);
    end

    // FIFO drained after 2 of 4 payload bytes
    pay.delete();
    fill(2, 8'h20);
    send(4'b0011, 4);
    wait_got(4, 50, "underrun");
`ifdef USB_TX_UNDERRUN_EN
    wait_done(100, "underrun");
    chk("underrun tx_err pulses", err_cnt - base_err, 1);
    build_exp(4'b0011, 2);
    chk("underrun load count", got.size() - base_got, 4);
    for (int i = 0; i < 4; i++)
      chk($sformatf("underrun byte%0d", i), int'(got[base_got + i]), int'(exp_q[i]));
    chk("underrun fifo_rd count", rd_cnt - base_rd, 2);
    chk("underrun send_eop count", eop_cnt - base_eop, 1);
`else
    begin
      int n0;
      n0 = got.size();
      repeat (20) @(negedge clk);
      #2;
      chk("underrun stall no loads", got.size() - n0, 0);
      chk("underrun stall busy", int'(busy), 1);
      chk("underrun stall no eop", eop_cnt - base_eop, 0);
    end
    fill(2, 8'h22);
    wait_done(200, "underrun");
    build_exp(4'b0011, 4);
    check_pkt("underrun", 4);
`endif

    // Asynchronous reset mid-packet
    pay.delete();
    fill(4, 8'h60);
    send(4'b0011, 4);
    wait_got(3, 50, "abort");
    #1 rst = 1'b1;
    #1;
    chk("abort byte_load", int'(byte_load), 0);
    chk("abort byte_out", int'(byte_out), 0);
    chk("abort fifo_rd", int'(fifo_rd), 0);
    chk("abort busy", int'(busy), 0);
    chk("abort send_eop", int'(send_eop), 0);
    chk("abort tx_done", int'(tx_done), 0);
    repeat (3) @(negedge clk);
    #2 rst = 1'b0;
    begin
      int n0;
      n0 = got.size();
      repeat (10) @(negedge clk);
      #2;
      chk("after abort no loads", got.size() - n0, 0);
      chk("after abort no eop", eop_cnt - base_eop, 0);
      chk("after abort busy", int'(busy), 0);
    end

    chk("no back-to-back loads", b2b_cnt, 0);
    chk("fifo_rd only with load", rd_noload_cnt, 0);
    chk("tx_done never with busy", overlap_cnt, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/usb_tx_sequencer.md
Name: usb_tx_sequencer

Overview:
- Packet-level controller for the USB 1.0 transmitter.
- Turns a send request (PID plus optional payload from the TX FIFO) into the byte stream SYNC, PID, DATA, CRC16.
- Loads each byte into byte_register through a ready/load handshake, then requests EOP from the line driver.
- Sits between the protocol engine or TX FIFO and the byte_register/serialiser datapath.

Parameters:
- MAX_LEN, 64, maximum payload bytes per data packet; larger data_len values are clamped to MAX_LEN.
- SYNC_BYTE, 8'h80, SYNC pattern loaded first; sent LSB-first as KJKJKJKK.

Ports:
- clk  in  1  system clock.
- rst  in  1  reset; asynchronous, active-high.
- start  in  1  single-cycle send request; accepted only in IDLE.
- pid  in  4  PID nibble, latched on accepted start.
- data_len  in  7  payload byte count (0..MAX_LEN), latched on accepted start.
- fifo_rdata  in  8  TX FIFO head byte (show-ahead).
- fifo_empty  in  1  TX FIFO empty.
- fifo_rd  out  1  pop pulse; coincident with byte_load of a payload byte.
- byte_req  in  1  byte_register can accept a byte.
- byte_load  out  1  one-cycle parallel-load strobe to byte_register.
- byte_out  out  8  byte to load; valid while byte_load=1.
- send_eop  out  1  one-cycle request to emit SE0,SE0,J.
- eop_done  in  1  line driver finished EOP.
- busy  out  1  high from accepted start until tx_done.
- tx_done  out  1  one-cycle pulse at packet end.
- tx_err  out  1  underrun pulse; exists only with USB_TX_UNDERRUN_EN.

Behaviour:
- Reset state: IDLE; byte_load, byte_out, fifo_rd, send_eop, busy, tx_done, tx_err, CRC register and length counter all 0.
  - Reset asserted mid-packet aborts immediately.
  - No EOP is sent on abort.
- All outputs are registered.
- Packet type from latched pid[1:0]:
  - 2'b11 (DATA0/DATA1): data packet.
  - Any other value: handshake packet (PID byte only).
- FSM states and transitions:
  - IDLE: start=1 → SYNC and busy=1 on the next edge. start while busy is ignored, with no queuing.
  - SYNC: load SYNC_BYTE → PID.
  - PID: load {~pid, pid}.
    - Handshake packet → WAIT_LAST.
    - Data packet with len=0 → CRC_LO.
    - Data packet with len>0 → DATA.
  - DATA: load fifo_rdata with fifo_rd=1, update CRC, decrement count; count reaching 0 → CRC_LO.
  - CRC_LO: load ~crc[7:0] → CRC_HI.
  - CRC_HI: load ~crc[15:8] → WAIT_LAST.
  - WAIT_LAST: wait until byte_req=1 (last byte consumed) → EOP with send_eop=1 for one cycle.
  - EOP: wait for eop_done=1 → IDLE, tx_done=1 for one cycle, busy=0 on the same edge.
- Load rule:
  - A byte-emitting state issues byte_load on the edge after it samples byte_req=1.
  - DATA additionally requires fifo_empty=0.
  - byte_req is ignored in the cycle immediately after a load, covering consumer deassert latency.
  - Loads are never back-to-back.
- CRC16:
  - Polynomial x^16+x^15+x^2+1, initialised to 16'hFFFF on accepted start.
  - Processes payload bits LSB-first, one byte per load.
  - Transmitted ones-complemented, low byte first.
  - Empty payload transmits 8'h00, 8'h00.
- Count is 7 bits; data_len > MAX_LEN is latched as MAX_LEN.
- FIFO empty in DATA (without the macro): stall; no load and no pop until data arrives. The bit stream may gap, so the upstream must prefill.
- eop_done arriving outside the EOP state is ignored.

Optional Feature:
- Macro: USB_TX_UNDERRUN_EN.
- Defined:
  - fifo_empty=1 sampled in DATA together with byte_req=1 → tx_err pulse for one cycle.
  - CRC bytes are skipped, and the FSM moves to WAIT_LAST then EOP.
  - The truncated packet fails CRC at the host.
  - tx_done still pulses at the end.
- Undefined: tx_err port absent; stall behaviour as above.

Test Plan:
- Reset then idle with byte_req=1 → no byte_load, busy=0, tx_done=0; reset mid-packet → all outputs 0 within the same cycle (asynchronous).
- ACK handshake (pid=4'b0010): loads 8'h80, 8'hD2 → send_eop once → eop_done → tx_done pulse; no fifo_rd.
- DATA0 (pid=4'b0011), data_len=0: loads 8'h80, 8'hC3, 8'h00, 8'h00 → EOP.
- DATA1 (pid=4'b1011), FIFO holds 8'h00, 8'h01, 8'h02, 8'h03: four fifo_rd pulses; CRC bytes match the bench reference model; byte_req held low for 20 cycles mid-payload → no load until it rises.
- data_len=100 with FIFO prefilled → exactly 64 payload loads; start pulsed mid-packet → ignored.
- FIFO drained after 2 of 4 bytes:
  - Without macro: stall, then resume when refilled.
  - With USB_TX_UNDERRUN_EN: tx_err pulse, no CRC bytes, then EOP and tx_done.
